// File: rtl/free_list.sv
// free_list: physical-register free list for the rename stage.
//
// A circular FIFO of unmapped physical register tags. Dispatch pops up to N
// tags per cycle (lane N-1 is oldest and is served first), and retirement
// pushes up to N old mappings (Told) back per cycle. A third pointer,
// arch_head, follows the head as seen by retirement. On a branch mispredict,
// head snaps back to it so the list matches the architectural map table.
//
// Pointers are PW bits wide. The low PW-1 bits index fl_array and the MSB is
// a wrap bit, so a full list (tail - head == FL_DEPTH) and an empty list
// (tail == head) can be told apart.
//
// Optional build macro:
//   FREE_LIST_CHECK_EN - adds a sticky fl_error output. It flags pointer
//                        invariant violations and reports them with $error.

module free_list #(
    parameter int ARCH_COUNT = 32,
    parameter int PHYS_REGS  = 64,
    parameter int N          = 3,
    localparam int FL_DEPTH  = PHYS_REGS - ARCH_COUNT,
    localparam int PRW       = $clog2(PHYS_REGS),
    localparam int PW        = $clog2(FL_DEPTH) + 1
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [N-1:0]     alloc_req,
    output logic [N*PRW-1:0] alloc_pr,
    output logic             alloc_ok,
    input  logic [N-1:0]     Retire_EN,
    input  logic [N*PRW-1:0] Told_in,
    input  logic             BPRecoverEN,
    output logic [PW-1:0]    free_count
`ifdef FREE_LIST_CHECK_EN
    ,
    output logic             fl_error
`endif
);

    localparam int IW = PW - 1;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [PRW-1:0] fl_array [FL_DEPTH];
    logic [PW-1:0]  head;
    logic [PW-1:0]  tail;
    logic [PW-1:0]  arch_head;

    // ------------------------------------------------------------------
    // Per-lane views of the packed tag buses
    // ------------------------------------------------------------------
    logic [PRW-1:0] told_lane [N];
    logic [N-1:0]   push_valid;

    // Split Told_in into lanes. A zero tag means "no old mapping" (x0), which
    // is never returned to the list.
    always_comb begin
        for (int i = 0; i < N; i++) begin
            told_lane[i]  = Told_in[i*PRW +: PRW];
            push_valid[i] = Retire_EN[i] && (told_lane[i] != '0);
        end
    end

    // ------------------------------------------------------------------
    // Allocation: compact the requesting lanes onto consecutive entries
    // starting at head, oldest lane first.
    // ------------------------------------------------------------------
    logic [PW-1:0] pop_off [N];
    logic [PW-1:0] pop_cnt;

    // Offset of each requesting lane from head, and the total number popped.
    always_comb begin
        // NOTE: every variable written here gets a value before any branch.
        // This keeps the block purely combinational, with no latch inferred.
        logic [PW-1:0] cnt;
        cnt = '0;
        for (int i = N - 1; i >= 0; i--) begin
            pop_off[i] = cnt;
            if (alloc_req[i]) begin
                cnt = cnt + PW'(1);
            end
        end
        pop_cnt = cnt;
    end

    // Granted tags are read straight from registered state, so they are
    // available in the same cycle. Lanes that do not request read zero.
    always_comb begin
        logic [PW-1:0] idx;
        alloc_pr = '0;
        idx      = '0;
        for (int i = 0; i < N; i++) begin
            idx = head + pop_off[i];
            if (alloc_req[i]) begin
                alloc_pr[i*PRW +: PRW] = fl_array[idx[IW-1:0]];
            end
        end
    end

    // The grant compares against the registered count. Tags freed this cycle
    // are not yet visible, and recovery blocks allocation entirely.
    assign alloc_ok = (pop_cnt <= free_count) && !BPRecoverEN;

    // ------------------------------------------------------------------
    // Free: compact the valid retire lanes onto consecutive entries
    // starting at tail, oldest lane first.
    // ------------------------------------------------------------------
    logic [PW-1:0] push_idx [N];
    logic [PW-1:0] push_cnt;

    // Write slot of each pushing lane, and the total number pushed.
    always_comb begin
        logic [PW-1:0] cnt;
        cnt = '0;
        for (int i = N - 1; i >= 0; i--) begin
            push_idx[i] = tail + cnt;
            if (push_valid[i]) begin
                cnt = cnt + PW'(1);
            end
        end
        push_cnt = cnt;
    end

    // ------------------------------------------------------------------
    // Next-state pointer arithmetic (all modulo 2^PW)
    // ------------------------------------------------------------------
    logic [PW-1:0] head_next;
    logic [PW-1:0] tail_next;
    logic [PW-1:0] arch_head_next;
    logic [PW-1:0] free_count_next;

    // Each retired Told means that instruction's Tnew is now architectural,
    // so arch_head advances in step with tail. Recovery restores head from
    // arch_head after this cycle's retires are applied.
    always_comb begin
        tail_next      = tail + push_cnt;
        arch_head_next = arch_head + push_cnt;
        if (BPRecoverEN) begin
            head_next = arch_head_next;
        end else if (alloc_ok) begin
            head_next = head + pop_cnt;
        end else begin
            head_next = head;
        end
        free_count_next = tail_next - head_next;
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------

    // Tag storage: preloaded with the unmapped PRs, written by retirement.
    always_ff @(posedge clock or negedge reset) begin
        // NOTE: this array is reset, unlike a plain RAM. After reset the list
        // must already hold PRs ARCH_COUNT..PHYS_REGS-1, because dispatch can
        // pop them in the first cycle.
        if (!reset) begin
            for (int i = 0; i < FL_DEPTH; i++) begin
                fl_array[i] <= PRW'(ARCH_COUNT + i);
            end
        end else begin
            for (int i = 0; i < N; i++) begin
                if (push_valid[i]) begin
                    fl_array[push_idx[i][IW-1:0]] <= told_lane[i];
                end
            end
        end
    end

    // Pointers and the registered occupancy count.
    always_ff @(posedge clock or negedge reset) begin
        // NOTE: state is assigned with <= only. Every register then samples
        // the values from before the edge, whatever the statement order.
        if (!reset) begin
            head       <= '0;
            arch_head  <= '0;
            tail       <= {1'b1, {IW{1'b0}}};
            free_count <= PW'(FL_DEPTH);
        end else begin
            head       <= head_next;
            arch_head  <= arch_head_next;
            tail       <= tail_next;
            free_count <= free_count_next;
        end
    end

`ifdef FREE_LIST_CHECK_EN
    // ------------------------------------------------------------------
    // Invariant checker
    // ------------------------------------------------------------------
    logic [PW-1:0] tail_span;
    logic [PW-1:0] head_span;
    logic          check_fail;

    // The list can never hold more than FL_DEPTH tags. In addition,
    // arch_head must never overtake head, which shows up as a negative
    // (wrapped) head span.
    always_comb begin
        tail_span  = tail_next - arch_head_next;
        head_span  = head_next - arch_head_next;
        check_fail = (tail_span > PW'(FL_DEPTH)) || (head_span > PW'(FL_DEPTH));
    end

    // Sticky error flag with a one-line report of the offending pointers.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            fl_error <= 1'b0;
        end else if (check_fail) begin
            fl_error <= 1'b1;
            $error("free_list: pointer invariant broken head=%0d tail=%0d arch_head=%0d",
                   head_next, tail_next, arch_head_next);
        end
    end
`endif

endmodule

// File: tb/tb_free_list.sv
// tb_free_list: directed, table-driven bench for free_list (N=3, 32 free PRs).
// Each table row is one clock cycle. The bench drives the inputs, checks the
// combinational grant, clocks the design, and then checks the registered
// free_count. Hand-written sequences cover draining, recovery and a
// mid-cycle reset.

module tb_free_list;

    localparam int N   = 3;
    localparam int PRW = 6;
    localparam int PW  = 6;

    logic             clock;
    logic             reset;
    logic [N-1:0]     alloc_req;
    logic [N*PRW-1:0] alloc_pr;
    logic             alloc_ok;
    logic [N-1:0]     Retire_EN;
    logic [N*PRW-1:0] Told_in;
    logic             BPRecoverEN;
    logic [PW-1:0]    free_count;
`ifdef FREE_LIST_CHECK_EN
    logic             fl_error;
`endif

    free_list #(.ARCH_COUNT(32), .PHYS_REGS(64), .N(N)) dut (
        .clock       (clock),
        .reset       (reset),
        .alloc_req   (alloc_req),
        .alloc_pr    (alloc_pr),
        .alloc_ok    (alloc_ok),
        .Retire_EN   (Retire_EN),
        .Told_in     (Told_in),
        .BPRecoverEN (BPRecoverEN),
        .free_count  (free_count)
`ifdef FREE_LIST_CHECK_EN
        ,
        .fl_error    (fl_error)
`endif
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input int actual, input int expected);
        n_tests++;
        if (actual != expected) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, actual, expected);
        end
    endtask

    task automatic drive(input logic [2:0] req, input logic [2:0] ret,
                         input int t2, input int t1, input int t0, input logic rec);
        alloc_req   = req;
        Retire_EN   = ret;
        Told_in     = {PRW'(t2), PRW'(t1), PRW'(t0)};
        BPRecoverEN = rec;
    endtask

    task automatic do_reset();
        @(negedge clock);
        drive(3'b000, 3'b000, 0, 0, 0, 1'b0);
        reset = 1'b0;
        @(negedge clock);
        @(negedge clock);
        reset = 1'b1;
    endtask

    // One cycle: drive at the negedge, check the grant 1ns later, clock, then
    // check free_count 1ns after the edge.
    task automatic cycle(input string name, input logic [2:0] req, input logic [2:0] ret,
                         input int t2, input int t1, input int t0, input logic rec,
                         input int exp_ok, input int exp_fc);
        @(negedge clock);
        drive(req, ret, t2, t1, t0, rec);
        #1;
        check({name, ".ok"}, int'(alloc_ok), exp_ok);
        @(posedge clock);
        #1;
        check({name, ".fc"}, int'(free_count), exp_fc);
    endtask

    function automatic int lane(input int i);
        return int'(alloc_pr[i*PRW +: PRW]);
    endfunction

    typedef struct {
        bit [2:0] req;
        bit [2:0] ret;
        int       t2, t1, t0;
        bit       rec;
        int       exp_ok;
        bit       chk_pr;
        int       pr2, pr1, pr0;
        int       fc;
    } vec_t;

    vec_t vecs[8];

    initial begin
        reset = 1'b1;
        drive(3'b000, 3'b000, 0, 0, 0, 1'b0);

        // Reset state, checked while reset is still asserted.
        #2 reset = 1'b0;
        #1;
        check("reset.fc", int'(free_count), 32);
        check("reset.ok", int'(alloc_ok), 1);
        check("reset.pr", int'(alloc_pr), 0);
        @(negedge clock);
        reset = 1'b1;

        // Table from reset. Expected free_count is sampled after each edge.
        vecs[0] = '{3'b111, 3'b000, 0, 0, 0, 1'b0, 1, 1'b1, 32, 33, 34, 29};
        vecs[1] = '{3'b100, 3'b000, 0, 0, 0, 1'b0, 1, 1'b1, 35, 0, 0, 28};
        vecs[2] = '{3'b101, 3'b000, 0, 0, 0, 1'b0, 1, 1'b1, 36, 0, 37, 26};
        vecs[3] = '{3'b000, 3'b110, 5, 7, 9, 1'b0, 1, 1'b1, 0, 0, 0, 28};
        vecs[4] = '{3'b010, 3'b111, 0, 11, 12, 1'b0, 1, 1'b1, 0, 38, 0, 29};
        vecs[5] = '{3'b111, 3'b100, 20, 0, 0, 1'b1, 0, 1'b0, 0, 0, 0, 32};
        vecs[6] = '{3'b100, 3'b000, 0, 0, 0, 1'b0, 1, 1'b1, 37, 0, 0, 31};
        vecs[7] = '{3'b011, 3'b000, 0, 0, 0, 1'b0, 1, 1'b1, 0, 38, 39, 29};

        for (int v = 0; v < 8; v++) begin
            @(negedge clock);
            drive(vecs[v].req, vecs[v].ret, vecs[v].t2, vecs[v].t1, vecs[v].t0, vecs[v].rec);
            #1;
            check($sformatf("vec%0d.ok", v), int'(alloc_ok), vecs[v].exp_ok);
            if (vecs[v].chk_pr) begin
                check($sformatf("vec%0d.pr2", v), lane(2), vecs[v].pr2);
                check($sformatf("vec%0d.pr1", v), lane(1), vecs[v].pr1);
                check($sformatf("vec%0d.pr0", v), lane(0), vecs[v].pr0);
            end
            @(posedge clock);
            #1;
            check($sformatf("vec%0d.fc", v), int'(free_count), vecs[v].fc);
        end

        // Drain to the boundary, then refill through retirement.
        do_reset();
        for (int k = 0; k < 10; k++) begin
            @(negedge clock);
            drive(3'b111, 3'b000, 0, 0, 0, 1'b0);
        end
        @(negedge clock);
        drive(3'b000, 3'b000, 0, 0, 0, 1'b0);
        #1;
        check("drain.fc2", int'(free_count), 2);
        cycle("drain.one", 3'b100, 3'b000, 0, 0, 0, 1'b0, 1, 1);
        cycle("drain.two_at_1", 3'b011, 3'b000, 0, 0, 0, 1'b0, 0, 1);
        @(negedge clock);
        drive(3'b100, 3'b000, 0, 0, 0, 1'b0);
        #1;
        check("drain.last_pr2", lane(2), 63);
        @(posedge clock);
        #1;
        check("drain.empty_fc", int'(free_count), 0);
        cycle("empty.no_req", 3'b000, 3'b000, 0, 0, 0, 1'b0, 1, 0);
        cycle("empty.no_bypass", 3'b100, 3'b110, 5, 7, 0, 1'b0, 0, 2);
        @(negedge clock);
        drive(3'b110, 3'b000, 0, 0, 0, 1'b0);
        #1;
        check("refill.pr2", lane(2), 5);
        check("refill.pr1", lane(1), 7);
        check("refill.ok", int'(alloc_ok), 1);
        @(posedge clock);
        #1;
        check("refill.fc", int'(free_count), 0);
        cycle("told_zero", 3'b000, 3'b100, 0, 0, 0, 1'b0, 1, 0);

        // Recovery with a simultaneous retire.
        do_reset();
        cycle("rec.a0", 3'b111, 3'b000, 0, 0, 0, 1'b0, 1, 29);
        cycle("rec.a1", 3'b111, 3'b000, 0, 0, 0, 1'b0, 1, 26);
        cycle("rec.recover", 3'b111, 3'b110, 3, 4, 0, 1'b1, 0, 32);
        @(negedge clock);
        drive(3'b100, 3'b000, 0, 0, 0, 1'b0);
        #1;
        check("rec.pr2", lane(2), 34);

        // Asynchronous reset between edges.
        do_reset();
        cycle("mid.a0", 3'b111, 3'b000, 0, 0, 0, 1'b0, 1, 29);
        cycle("mid.a1", 3'b111, 3'b000, 0, 0, 0, 1'b0, 1, 26);
        @(negedge clock);
        drive(3'b100, 3'b000, 0, 0, 0, 1'b0);
        #1;
        check("mid.pre_pr2", lane(2), 38);
        #1 reset = 1'b0;
        #1;
        check("mid.fc", int'(free_count), 32);
        check("mid.pr2", lane(2), 32);
        check("mid.ok", int'(alloc_ok), 1);
        @(negedge clock);
        reset = 1'b1;

`ifdef FREE_LIST_CHECK_EN
        // Pushing with nothing allocated makes arch_head overtake head.
        do_reset();
        check("err.reset", int'(fl_error), 0);
        for (int k = 0; k < 11; k++) begin
            @(negedge clock);
            drive(3'b000, 3'b111, 1, 2, 3, 1'b0);
        end
        @(negedge clock);
        drive(3'b000, 3'b000, 0, 0, 0, 1'b0);
        #1;
        check("err.set", int'(fl_error), 1);
        repeat (3) @(negedge clock);
        check("err.sticky", int'(fl_error), 1);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/free_list.md
# free_list

Physical-register free list for the rename stage: a circular FIFO of unmapped physical register tags that supplies up to N new tags per cycle to the map table and takes back up to N `Told` tags per cycle from retirement. It sits between dispatch/rename (producer of `maptable_new_pr`) and the ROB retire port (consumer of `Told_out`). It keeps a retire-side head pointer so that on `BPRecoverEN` it returns to the precise state matching the architectural map table.

## Interface
- `ARCH_COUNT`, 32, architectural registers; at reset PRs `0..ARCH_COUNT-1` are mapped (identity).
- `PHYS_REGS`, 64, physical registers; `FL_DEPTH = PHYS_REGS-ARCH_COUNT` is the FIFO depth and must be a power of two.
- `N`, 3, superscalar width; lane N-1 is oldest.
- `PRW` (localparam), `$clog2(PHYS_REGS)`, tag width. `PW` (localparam), `$clog2(FL_DEPTH)+1`, pointer width including wrap bit.

Ports:
- `clock`  in  1  single clock, rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `alloc_req`  in  N  lane requests a new PR; asserted only for lanes with rd != x0.
- `alloc_pr`  out  N×PRW  granted tag per lane; `'0` on non-requesting lanes.
- `alloc_ok`  out  1  request fits; allocation takes effect at the edge only when 1.
- `Retire_EN`  in  N  retiring lane frees `Told_in`.
- `Told_in`  in  N×PRW  old mapping being freed.
- `BPRecoverEN`  in  1  mispredict recovery, same cycle as map-table recovery.
- `free_count`  out  PW  registered number of free entries (0..FL_DEPTH).

## Operation
- State: `fl_array[FL_DEPTH]` of PRW tags; `head`, `tail`, `arch_head` each PW bits; index = low `PW-1` bits, MSB = wrap bit.
- Allocation: requesting lanes, in order N-1 down to 0, take consecutive entries `fl_array[head]`, `fl_array[head+1]`, …; non-requesting lanes consume nothing. `alloc_ok = (popcount(alloc_req) <= free_count) && !BPRecoverEN`. When `alloc_ok` = 0 nothing is popped and `alloc_pr` values are don't-care to the consumer. `alloc_ok` = 1 when no lane requests.
- Free: valid retire lanes with `Told_in != 0` are written, oldest first, to `fl_array[tail]`, `fl_array[tail+1]`, …; `tail` advances by that count. `arch_head` advances by the same count, since each such instruction's Tnew becomes architectural. Lanes with `Told_in == 0` are no-ops for both pointers.
- Recovery: `head_next = arch_head_next`, which includes this cycle's retires. Allocation is suppressed. After recovery `free_count == FL_DEPTH`.
- `free_count_next = tail_next - head_next`, computed modulo `2^PW`. Pointers wrap naturally at `2^PW`.
- Invariant: `tail - arch_head <= FL_DEPTH`. Push-on-full cannot occur in legal operation.

## Timing
- Reset (asserted low, asynchronous): `head = arch_head = 0`; `tail = {1'b1, '0}` (full); `fl_array[i] = ARCH_COUNT+i`; `free_count = FL_DEPTH`. Outputs follow combinationally: `alloc_ok = 1`, `alloc_pr = 0` with no requests.
- Reset asserted mid-operation: all state returns to reset values immediately, with no wait for `clock`.
- `alloc_pr` and `alloc_ok` are combinational from registered state and the current inputs, with zero-cycle latency.
- Pointers and `free_count` update at the rising edge.
- Tags freed in cycle t are allocatable from cycle t+1. There is no same-cycle bypass, and `alloc_ok` uses the registered `free_count`.
- Simultaneous allocate and free in one cycle: both apply. Simultaneous recover and retire: retire applies, then head is restored.

## Configuration
- `FREE_LIST_CHECK_EN` defined: adds output `fl_error` (1 bit, reset 0, sticky). It is set at the edge when:
  - `tail_next - arch_head_next > FL_DEPTH`, or
  - `head_next - arch_head_next > FL_DEPTH` (arch_head overtakes head).
  It also prints `$error` with the offending pointers.
- Undefined: no `fl_error` port and no check logic. All other behaviour is identical.

## Test plan
- Reset, `alloc_req=3'b111` -> `alloc_ok=1`, `alloc_pr={32,33,34}` (lanes 2,1,0); next cycle `free_count=29`, then `alloc_pr[2]=35`.
- Partial request `alloc_req=3'b101` after reset -> lane2=32, lane1=0, lane0=33; `free_count=30`.
- Drain to `free_count=1`, request `3'b011` -> `alloc_ok=0`; `head` and `free_count` unchanged next cycle.
- `Retire_EN=3'b110`, `Told_in={5,7,x}` at `free_count=0` -> `free_count=2`; next allocation of two lanes yields 5 then 7. Also check `Told_in=0` on an enabled lane -> no push.
- Allocate 6 from reset, then `BPRecoverEN` with `Retire_EN=3'b110`, Told {3,4} -> `alloc_ok=0` that cycle; next `free_count=32`, `alloc_pr[2]=34`.
- Assert `reset` mid-allocation between edges -> `free_count=32` and `alloc_pr[2]=32` immediately. With `FREE_LIST_CHECK_EN`, force 33 pushes -> `fl_error=1` and stays 1.
